// File: rtl/fp_normalize_seq.sv
// fp_normalize_seq
// Post-add normalizer for a floating-point adder. It takes one raw sum
// (biased exponent plus an M+1 bit mantissa with carry), normalizes it one
// shift per cycle and presents the result until downstream takes it. Only
// one operand is in flight at a time.
//
// Ports
//   clk        single clock, rising edge
//   rstn       asynchronous active-low reset
//   in_valid   upstream operand valid
//   in_ready   block accepts an operand this cycle (IDLE only)
//   in_exp     unsigned biased exponent of the raw sum (N bits)
//   in_man     raw sum (M+1 bits): bit M = carry, bit M-1 = leading-one slot
//   out_valid  result valid
//   out_ready  downstream accepts the result
//   out_exp    normalized exponent (N bits)
//   out_man    normalized mantissa incl. explicit leading one (M bits)
//   out_zero   result is zero
//   out_ovf    exponent overflow (exp forced to all ones, mantissa 0)
//   out_unf    exponent underflow (exp forced to 0, mantissa unshifted)
//   dbg_state  current FSM state (IDLE=0, SHIFT=1, DONE=2)
//
// Handshake: a transfer happens on a rising edge where valid and ready are
// both 1. The upstream side transfers only in IDLE; the downstream side
// transfers only in DONE once out_valid is up. Outside those windows
// in_valid and out_ready are ignored. Once out_valid is 1 every output is
// held until the transfer edge.
`timescale 1ns/1ps
module fp_normalize_seq #(
    parameter int N = 8,
    parameter int M = 24
) (
    input  logic         clk,
    input  logic         rstn,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [N-1:0] in_exp,
    input  logic [M:0]   in_man,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [N-1:0] out_exp,
    output logic [M-1:0] out_man,
    output logic         out_zero,
    output logic         out_ovf,
    output logic         out_unf,
    output logic [1:0]   dbg_state
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_t;

    // A carry at or above this exponent would push it to/through all ones.
    localparam logic [N-1:0] E_OVF = {{(N-1){1'b1}}, 1'b0};
    localparam logic [N-1:0] ONE   = {{(N-1){1'b0}}, 1'b1};

    state_t       state, state_nxt;
    logic [N-1:0] e;
    logic [M:0]   m;
    logic         zero_f, ovf_f, unf_f;
    logic         valid_q;
    // Keeps in_ready low during reset and until the first edge after release.
    logic         armed;

    logic accept, release_res;
    logic c_zero, c_ovf, c_carry, c_norm, c_unf, c_left;

    assign accept      = in_ready && in_valid;
    assign release_res = (state == DONE) && valid_q && out_ready;

    // Classification of the working value, highest priority first.
    always_comb begin
        c_zero  = 1'b0;
        c_ovf   = 1'b0;
        c_carry = 1'b0;
        c_norm  = 1'b0;
        c_unf   = 1'b0;
        c_left  = 1'b0;
        if (m == '0) begin
            c_zero = 1'b1;
        end else if (m[M]) begin
            if (e >= E_OVF) c_ovf = 1'b1;
            else            c_carry = 1'b1;
        end else if (m[M-1]) begin
            c_norm = 1'b1;
        end else if (e <= ONE) begin
            c_unf = 1'b1;
        end else begin
            c_left = 1'b1;
        end
    end

    // State register
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) state <= IDLE;
        else       state <= state_nxt;
    end

    // Next-state logic
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (accept) state_nxt = SHIFT;
            SHIFT:   if (!c_left) state_nxt = DONE;
            DONE:    if (release_res) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Output logic
    always_comb begin
        in_ready  = armed && (state == IDLE);
        dbg_state = state;
        out_valid = valid_q;
        out_exp   = e;
        out_man   = m[M-1:0];
        // Flags are only meaningful while a result is presented.
        out_zero  = zero_f && valid_q;
        out_ovf   = ovf_f  && valid_q;
        out_unf   = unf_f  && valid_q;
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) armed <= 1'b0;
        else       armed <= 1'b1;
    end

    // Datapath: capture, one normalization step per SHIFT cycle, and the
    // result presentation. out_valid rises on the first edge spent in DONE.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            e       <= '0;
            m       <= '0;
            zero_f  <= 1'b0;
            ovf_f   <= 1'b0;
            unf_f   <= 1'b0;
            valid_q <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (accept) begin
                        e      <= in_exp;
                        m      <= in_man;
                        zero_f <= 1'b0;
                        ovf_f  <= 1'b0;
                        unf_f  <= 1'b0;
                    end
                end
                SHIFT: begin
                    if (c_zero) begin
                        e      <= '0;
                        zero_f <= 1'b1;
                    end else if (c_ovf) begin
                        e     <= '1;
                        m     <= '0;
                        ovf_f <= 1'b1;
                    end else if (c_carry) begin
                        m <= m >> 1;
                        e <= e + ONE;
                    end else if (c_unf) begin
                        e     <= '0;
                        unf_f <= 1'b1;
                    end else if (c_left) begin
                        m <= m << 1;
                        e <= e - ONE;
                    end
                    // c_norm: already normalized, nothing changes.
                end
                DONE: begin
                    if (!valid_q) begin
                        valid_q <= 1'b1;
                    end else if (out_ready) begin
                        valid_q <= 1'b0;
                        zero_f  <= 1'b0;
                        ovf_f   <= 1'b0;
                        unf_f   <= 1'b0;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule
